decode_issue_stage: RTL and testbench

- Parametrised successor to the single-cycle decode stage: decodes RV32I(+M) instructions and resolves operands through an N-channel bypass network plus a per-register pending-write scoreboard.
- Stalls on unresolved RAW hazards and registers the decoded micro-op behind a valid/ready handshake.
- Sits between fetch and execute. The register file is external and read combinationally through address/data ports.

---
 rtl/decode_issue_stage_pkg.sv | 63 ++++++
 rtl/decode_issue_stage_reg_scoreboard.sv | 65 ++++++
 rtl/decode_issue_stage.sv | 197 +++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_stage_pkg.sv
// Shared types for the decode/issue stage: micro-op layout, RV32 opcodes and immediate classes.
// The DEC_MEXT_EN macro (see decode_issue_stage.sv) changes decode only, not these types.
package decode_issue_stage_pkg;

  localparam int DEC_XLEN = 32;
  localparam int DEC_RW   = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [DEC_XLEN-1:0] pc;
    logic [DEC_RW-1:0]   rd;
    logic [DEC_XLEN-1:0] rs1_data;
    logic [DEC_XLEN-1:0] rs2_data;
    logic [DEC_XLEN-1:0] imm;
    logic [2:0]          func3;
    logic [6:0]          func7;
    imm_type_e           imm_type;
    logic                is_load;
    logic                is_store;
    logic                is_branch;
    logic                is_jal;
    logic                is_jalr;
    logic                is_lui;
    logic                is_auipc;
    logic                is_alu;
    logic                we;
    logic                is_mul;
    logic                illegal;
  } dec_uop_t;

  // Sign-extended immediate for each RV32 instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_e t);
    case (t)
      IMM_I:   return {{20{inst[31]}}, inst[31:20]};
      IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   return {inst[31:12], 12'b0};
      IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_stage_reg_scoreboard.sv
// Per-register in-flight write counters: one allocate and two release ports per cycle.
// Releases that would take a counter below zero are dropped.
module reg_scoreboard
  import decode_issue_stage_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int SB_CNT_W = 2,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  input  logic [RW-1:0]       alloc_rd,
  input  logic                release_valid,
  input  logic [RW-1:0]       release_rd,
  input  logic                release2_valid,
  input  logic [RW-1:0]       release2_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic [NUM_REGS-1:0] saturated
);

  localparam int CW = SB_CNT_W + 2;
  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

  logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
  logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] underflow;

  always_comb begin : next_cnt
    logic [CW-1:0] sum;
    logic [CW-1:0] dec;
    logic [CW-1:0] diff;
    underflow = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sum  = CW'(cnt_q[r]) + CW'(alloc_valid && alloc_rd == RW'(r) && r != 0);
      dec  = CW'(release_valid && release_rd == RW'(r) && r != 0)
           + CW'(release2_valid && release2_rd == RW'(r) && r != 0);
      diff = '0;
      cnt_d[r] = cnt_q[r];
      if (dec > sum) begin
        underflow[r] = 1'b1;
        cnt_d[r]     = '0;
      end else begin
        diff     = sum - dec;
        cnt_d[r] = (diff > CW'(CNT_MAX)) ? CNT_MAX : diff[SB_CNT_W-1:0];
      end
      pending[r]   = (cnt_q[r] != '0);
      saturated[r] = (cnt_q[r] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
`ifndef SYNTHESIS
      // A release with nothing pending means downstream lost track of an issued uop.
      assert (underflow == '0)
        else $error("reg_scoreboard: release of register with no pending write");
`endif
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage with bypass network, pending-write scoreboard and registered uop output.
// Optional M-extension decode is enabled by defining DEC_MEXT_EN.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int XLEN     = DEC_XLEN,
  parameter int NUM_REGS = 32,
  parameter int NUM_BYP  = 2,
  parameter int SB_CNT_W = 2,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    fetch_valid_i,
  output logic                    fetch_ready_o,
  input  logic [31:0]             fetch_inst_i,
  input  logic [XLEN-1:0]         fetch_pc_i,
  output logic [RW-1:0]           rf_rs1_addr_o,
  output logic [RW-1:0]           rf_rs2_addr_o,
  input  logic [XLEN-1:0]         rf_rs1_data_i,
  input  logic [XLEN-1:0]         rf_rs2_data_i,
  input  logic [NUM_BYP-1:0]      byp_valid_i,
  input  logic [NUM_BYP-1:0]      byp_ready_i,
  input  logic [NUM_BYP*RW-1:0]   byp_rd_i,
  input  logic [NUM_BYP*XLEN-1:0] byp_data_i,
  input  logic                    wb_valid_i,
  input  logic [RW-1:0]           wb_rd_i,
  output logic                    dec_valid_o,
  input  logic                    dec_ready_i,
  output dec_uop_t                dec_uop_o,
  output logic                    stall_o
);

  logic [6:0]    opcode;
  logic [RW-1:0] rd_a, rs1_a, rs2_a;
  imm_type_e     imm_type;
  logic          use_rs1, use_rs2, has_rd, we, illegal, is_mul;
  logic          is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_alu;

  logic [RW-1:0]   src_addr [2];
  logic [XLEN-1:0] src_rf   [2];
  logic [XLEN-1:0] src_val  [2];
  logic            src_haz  [2];

  logic [NUM_REGS-1:0] pending, saturated;
  logic                stall, load;
  logic                dec_valid_q;
  dec_uop_t            uop_q, new_uop;

  assign opcode = fetch_inst_i[6:0];
  assign rd_a   = RW'(fetch_inst_i[11:7]);
  assign rs1_a  = RW'(fetch_inst_i[19:15]);
  assign rs2_a  = RW'(fetch_inst_i[24:20]);

  always_comb begin
    imm_type  = IMM_NONE;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    has_rd    = 1'b0;
    illegal   = 1'b0;
    is_mul    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_lui    = 1'b0;
    is_auipc  = 1'b0;
    is_alu    = 1'b0;
    case (opcode)
      OP_LOAD:   begin imm_type = IMM_I; use_rs1 = 1'b1; has_rd = 1'b1; is_load = 1'b1; end
      OP_STORE:  begin imm_type = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1; end
      OP_OP: begin
        if (fetch_inst_i[31:25] == FUNC7_MULDIV) begin
`ifdef DEC_MEXT_EN
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          has_rd  = 1'b1;
          is_mul  = 1'b1;
`else
          illegal = 1'b1;
`endif
        end else begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          has_rd  = 1'b1;
          is_alu  = 1'b1;
        end
      end
      OP_IMM:    begin imm_type = IMM_I; use_rs1 = 1'b1; has_rd = 1'b1; is_alu = 1'b1; end
      OP_LUI:    begin imm_type = IMM_U; has_rd = 1'b1; is_lui = 1'b1; end
      OP_AUIPC:  begin imm_type = IMM_U; has_rd = 1'b1; is_auipc = 1'b1; end
      OP_BRANCH: begin imm_type = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; is_branch = 1'b1; end
      OP_JAL:    begin imm_type = IMM_J; has_rd = 1'b1; is_jal = 1'b1; end
      OP_JALR:   begin imm_type = IMM_I; use_rs1 = 1'b1; has_rd = 1'b1; is_jalr = 1'b1; end
      default:   illegal = 1'b1;
    endcase
    we = has_rd & (rd_a != '0);
  end

  assign src_addr[0]   = rs1_a;
  assign src_addr[1]   = rs2_a;
  assign src_rf[0]     = rf_rs1_data_i;
  assign src_rf[1]     = rf_rs2_data_i;
  assign rf_rs1_addr_o = rs1_a;
  assign rf_rs2_addr_o = rs2_a;

  // Youngest matching bypass channel owns the value; a matching but not-ready channel is a hazard
  // even if an older channel already has the data.
  always_comb begin : resolve
    logic found;
    for (int s = 0; s < 2; s++) begin
      src_val[s] = '0;
      src_haz[s] = 1'b0;
      found      = 1'b0;
      if (src_addr[s] != '0) begin
        for (int b = 0; b < NUM_BYP; b++) begin
          if (!found && byp_valid_i[b] && byp_rd_i[b*RW +: RW] == src_addr[s]) begin
            found = 1'b1;
            if (byp_ready_i[b]) src_val[s] = byp_data_i[b*XLEN +: XLEN];
            else                src_haz[s] = 1'b1;
          end
        end
        if (!found) begin
          if (pending[src_addr[s]]) src_haz[s] = 1'b1;
          else                      src_val[s] = src_rf[s];
        end
      end
    end
  end

  assign stall = fetch_valid_i & ((use_rs1 & src_haz[0]) | (use_rs2 & src_haz[1])
                                  | (we & saturated[rd_a]));
  assign fetch_ready_o = ~stall & (~dec_valid_q | dec_ready_i) & ~flush_i;
  assign load          = fetch_valid_i & fetch_ready_o;
  assign stall_o       = stall;

  always_comb begin
    new_uop           = '0;
    new_uop.pc        = fetch_pc_i;
    new_uop.rd        = rd_a;
    new_uop.rs1_data  = use_rs1 ? src_val[0] : '0;
    new_uop.rs2_data  = use_rs2 ? src_val[1] : '0;
    new_uop.imm       = imm_gen(fetch_inst_i, imm_type);
    new_uop.func3     = fetch_inst_i[14:12];
    new_uop.func7     = fetch_inst_i[31:25];
    new_uop.imm_type  = imm_type;
    new_uop.is_load   = is_load;
    new_uop.is_store  = is_store;
    new_uop.is_branch = is_branch;
    new_uop.is_jal    = is_jal;
    new_uop.is_jalr   = is_jalr;
    new_uop.is_lui    = is_lui;
    new_uop.is_auipc  = is_auipc;
    new_uop.is_alu    = is_alu;
    new_uop.we        = we;
    new_uop.is_mul    = is_mul;
    new_uop.illegal   = illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid_q <= 1'b0;
      uop_q       <= '0;
    end else if (flush_i) begin
      dec_valid_q <= 1'b0;
      uop_q       <= '0;
    end else if (load) begin
      dec_valid_q <= 1'b1;
      uop_q       <= new_uop;
    end else if (dec_ready_i) begin
      dec_valid_q <= 1'b0;
    end
  end

  assign dec_valid_o = dec_valid_q;
  assign dec_uop_o   = uop_q;

  // A flushed uop that never handshook will never be retired, so its allocation is returned here.
  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SB_CNT_W (SB_CNT_W)
  ) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid    (load & we),
    .alloc_rd       (rd_a),
    .release_valid  (wb_valid_i),
    .release_rd     (wb_rd_i),
    .release2_valid (flush_i & dec_valid_q & ~dec_ready_i & uop_q.we),
    .release2_rd    (RW'(uop_q.rd)),
    .pending        (pending),
    .saturated      (saturated)
  );

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage; honours DEC_MEXT_EN for the MUL vector.
module tb_decode_issue_stage;
  import decode_issue_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int NB   = 2;

  localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] ADD_X3_X1X2 = 32'h002081B3;
  localparam logic [31:0] ADD_X8_X5X0 = 32'h00028433;
  localparam logic [31:0] ADDI_X7_1   = 32'h00100393;
  localparam logic [31:0] ADDI_X9_3   = 32'h00300493;
  localparam logic [31:0] ADDI_X10_4  = 32'h00400513;
  localparam logic [31:0] ADDI_X11_1  = 32'h00100593;
  localparam logic [31:0] ADDI_X12_1  = 32'h00100613;
  localparam logic [31:0] MUL_X4_X5X6 = 32'h02628233;
  localparam logic [31:0] JAL_X1_NEG2 = 32'hFFFFF0EF;
  localparam logic [31:0] JAL_X1_800  = 32'h001000EF;
  localparam logic [31:0] SW_NEG4     = 32'hFE002E23;
  localparam logic [31:0] BAD_OPCODE  = 32'h00000FFF;
  localparam logic [31:0] NOP         = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush_i, fetch_valid_i, fetch_ready_o;
  logic [31:0]       fetch_inst_i;
  logic [XLEN-1:0]   fetch_pc_i;
  logic [RW-1:0]     rf_rs1_addr_o, rf_rs2_addr_o;
  logic [XLEN-1:0]   rf_rs1_data_i, rf_rs2_data_i;
  logic [NB-1:0]     byp_valid_i, byp_ready_i;
  logic [NB*RW-1:0]  byp_rd_i;
  logic [NB*XLEN-1:0] byp_data_i;
  logic              wb_valid_i;
  logic [RW-1:0]     wb_rd_i;
  logic              dec_valid_o, dec_ready_i, stall_o;
  dec_uop_t          dec_uop_o;

  int                compared = 0;
  int                mismatched = 0;
  logic [31:0]       pcNext = 32'h0000_0080;
  logic [31:0]       expPc;

  always #5 clk = ~clk;

  // External register file: register n reads as 0x1000+n.
  assign rf_rs1_data_i = 32'h1000 + 32'(rf_rs1_addr_o);
  assign rf_rs2_data_i = 32'h1000 + 32'(rf_rs2_addr_o);

  decode_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_inst_i  (fetch_inst_i),
    .fetch_pc_i    (fetch_pc_i),
    .rf_rs1_addr_o (rf_rs1_addr_o),
    .rf_rs2_addr_o (rf_rs2_addr_o),
    .rf_rs1_data_i (rf_rs1_data_i),
    .rf_rs2_data_i (rf_rs2_data_i),
    .byp_valid_i   (byp_valid_i),
    .byp_ready_i   (byp_ready_i),
    .byp_rd_i      (byp_rd_i),
    .byp_data_i    (byp_data_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_uop_o     (dec_uop_o),
    .stall_o       (stall_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sbCnt(input int r);
    return 32'(dut.u_sb.cnt_q[r]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] inst);
    fetch_valid_i = valid;
    fetch_inst_i  = inst;
    fetch_pc_i    = pcNext;
    pcNext        = pcNext + 32'd4;
    #1;
  endtask

  task automatic releaseReg(input logic [RW-1:0] r);
    fetch_valid_i = 1'b0;
    wb_valid_i    = 1'b1;
    wb_rd_i       = r;
    tick();
    wb_valid_i    = 1'b0;
  endtask

  task automatic clearBypass();
    byp_valid_i = '0;
    byp_ready_i = '0;
    byp_rd_i    = '0;
    byp_data_i  = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_inst_i = '0;
    fetch_pc_i = '0;
    wb_valid_i = 1'b0;
    wb_rd_i = '0;
    dec_ready_i = 1'b1;
    clearBypass();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dec_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("rst_uop_zero", 32'(|dec_uop_o), 32'd0);
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
    checkOutput("rst_sb_x1", sbCnt(1), 32'd0);
    rst_n = 1'b1;
    tick();

    // ADDI x1,x0,5 issues after one cycle and allocates x1
    applyStimulus(1'b1, ADDI_X1_5);
    checkOutput("addi_fetch_ready", 32'(fetch_ready_o), 32'd1);
    tick();
    checkOutput("addi_dec_valid", 32'(dec_valid_o), 32'd1);
    checkOutput("addi_imm", dec_uop_o.imm, 32'd5);
    checkOutput("addi_we", 32'(dec_uop_o.we), 32'd1);
    checkOutput("addi_rd", 32'(dec_uop_o.rd), 32'd1);
    checkOutput("addi_rs1_x0", dec_uop_o.rs1_data, 32'd0);
    checkOutput("addi_sb_x1", sbCnt(1), 32'd1);
    wb_valid_i = 1'b1;
    wb_rd_i = 5'd1;
    applyStimulus(1'b1, ADDI_X1_5);
    tick();
    wb_valid_i = 1'b0;
    checkOutput("alloc_rel_same", sbCnt(1), 32'd1);
    releaseReg(5'd1);
    checkOutput("wb_sb_x1", sbCnt(1), 32'd0);
    checkOutput("idle_dec_valid", 32'(dec_valid_o), 32'd0);

    // RAW on x1: scoreboard stall, then unready bypass stall, then bypass data taken
    applyStimulus(1'b1, ADDI_X1_5);
    tick();
    applyStimulus(1'b1, ADD_X3_X1X2);
    checkOutput("sb_haz_stall", 32'(stall_o), 32'd1);
    byp_valid_i = 2'b01;
    byp_rd_i = {5'd0, 5'd1};
    #1;
    checkOutput("byp_nr_stall", 32'(stall_o), 32'd1);
    checkOutput("byp_nr_fready", 32'(fetch_ready_o), 32'd0);
    tick();
    checkOutput("byp_nr_noload", 32'(dec_valid_o), 32'd0);
    byp_ready_i = 2'b01;
    byp_data_i = {32'h0, 32'h2A};
    #1;
    checkOutput("byp_rdy_stall", 32'(stall_o), 32'd0);
    tick();
    checkOutput("byp_rs1", dec_uop_o.rs1_data, 32'h2A);
    checkOutput("rf_rs2", dec_uop_o.rs2_data, 32'h1002);
    checkOutput("add_sb_x3", sbCnt(3), 32'd1);
    clearBypass();
    releaseReg(5'd1);
    releaseReg(5'd3);
    checkOutput("rel_sb_x3", sbCnt(3), 32'd0);

    // Channel priority on x5
    byp_valid_i = 2'b11;
    byp_ready_i = 2'b11;
    byp_rd_i = {5'd5, 5'd5};
    byp_data_i = {32'h22, 32'h11};
    applyStimulus(1'b1, ADD_X8_X5X0);
    tick();
    checkOutput("byp_prio0", dec_uop_o.rs1_data, 32'h11);
    checkOutput("byp_rs2_x0", dec_uop_o.rs2_data, 32'h0);
    byp_valid_i = 2'b10;
    applyStimulus(1'b1, ADD_X8_X5X0);
    tick();
    checkOutput("byp_ch1_only", dec_uop_o.rs1_data, 32'h22);
    byp_valid_i = 2'b11;
    byp_ready_i = 2'b10;
    applyStimulus(1'b1, ADD_X8_X5X0);
    checkOutput("byp_prio_stall", 32'(stall_o), 32'd1);
    clearBypass();
    releaseReg(5'd8);
    releaseReg(5'd8);

    // Backpressure holds the uop stable
    dec_ready_i = 1'b0;
    applyStimulus(1'b1, ADDI_X9_3);
    tick();
    applyStimulus(1'b1, ADDI_X10_4);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_fready", 32'(fetch_ready_o), 32'd0);
      tick();
      checkOutput("hold_rd", 32'(dec_uop_o.rd), 32'd9);
    end
    dec_ready_i = 1'b1;
    #1;
    checkOutput("release_fready", 32'(fetch_ready_o), 32'd1);
    tick();
    checkOutput("next_rd", 32'(dec_uop_o.rd), 32'd10);
    checkOutput("next_imm", dec_uop_o.imm, 32'd4);
    fetch_valid_i = 1'b0;
    tick();
    releaseReg(5'd9);
    releaseReg(5'd10);

    // Flush of a held x7 uop combined with a writeback release of x7
    applyStimulus(1'b1, ADDI_X7_1);
    tick();
    applyStimulus(1'b1, ADDI_X7_1);
    tick();
    checkOutput("flush_pre_sb_x7", sbCnt(7), 32'd2);
    dec_ready_i = 1'b0;
    flush_i = 1'b1;
    wb_valid_i = 1'b1;
    wb_rd_i = 5'd7;
    applyStimulus(1'b1, ADDI_X9_3);
    checkOutput("flush_fready", 32'(fetch_ready_o), 32'd0);
    tick();
    checkOutput("flush_sb_x7", sbCnt(7), 32'd0);
    checkOutput("flush_dec_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("flush_sb_x9", sbCnt(9), 32'd0);
    flush_i = 1'b0;
    wb_valid_i = 1'b0;
    fetch_valid_i = 1'b0;
    dec_ready_i = 1'b1;
    tick();

    // MUL x4,x5,x6
    applyStimulus(1'b1, MUL_X4_X5X6);
    tick();
    fetch_valid_i = 1'b0;
`ifdef DEC_MEXT_EN
    checkOutput("mul_is_mul", 32'(dec_uop_o.is_mul), 32'd1);
    checkOutput("mul_we", 32'(dec_uop_o.we), 32'd1);
    checkOutput("mul_illegal", 32'(dec_uop_o.illegal), 32'd0);
    checkOutput("mul_sb_x4", sbCnt(4), 32'd1);
    releaseReg(5'd4);
`else
    checkOutput("mul_is_mul", 32'(dec_uop_o.is_mul), 32'd0);
    checkOutput("mul_we", 32'(dec_uop_o.we), 32'd0);
    checkOutput("mul_illegal", 32'(dec_uop_o.illegal), 32'd1);
    checkOutput("mul_sb_x4", sbCnt(4), 32'd0);
    tick();
`endif

    // Immediate formats, we gating and illegal opcode
    expPc = pcNext;
    applyStimulus(1'b1, JAL_X1_NEG2);
    tick();
    checkOutput("jal_neg_imm", dec_uop_o.imm, 32'hFFFF_FFFE);
    checkOutput("jal_we", 32'(dec_uop_o.we), 32'd1);
    checkOutput("jal_pc", dec_uop_o.pc, expPc);
    applyStimulus(1'b1, JAL_X1_800);
    tick();
    checkOutput("jal_pos_imm", dec_uop_o.imm, 32'h0000_0800);
    applyStimulus(1'b1, SW_NEG4);
    tick();
    checkOutput("sw_imm", dec_uop_o.imm, 32'hFFFF_FFFC);
    checkOutput("sw_we", 32'(dec_uop_o.we), 32'd0);
    applyStimulus(1'b1, BAD_OPCODE);
    tick();
    checkOutput("bad_illegal", 32'(dec_uop_o.illegal), 32'd1);
    checkOutput("bad_we", 32'(dec_uop_o.we), 32'd0);
    applyStimulus(1'b1, NOP);
    tick();
    checkOutput("nop_we_x0", 32'(dec_uop_o.we), 32'd0);
    checkOutput("jal_sb_x1", sbCnt(1), 32'd2);
    releaseReg(5'd1);
    releaseReg(5'd1);

    // Saturating the x11 counter stalls the fourth writer
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ADDI_X11_1);
      tick();
    end
    checkOutput("sat_sb_x11", sbCnt(11), 32'd3);
    applyStimulus(1'b1, ADDI_X11_1);
    checkOutput("sat_stall", 32'(stall_o), 32'd1);
    checkOutput("sat_fready", 32'(fetch_ready_o), 32'd0);
    tick();
    checkOutput("sat_hold_x11", sbCnt(11), 32'd3);
    for (int i = 0; i < 3; i++) releaseReg(5'd11);
    checkOutput("sat_drain_x11", sbCnt(11), 32'd0);

    // Asynchronous reset between clock edges
    dec_ready_i = 1'b0;
    applyStimulus(1'b1, ADDI_X12_1);
    tick();
    fetch_valid_i = 1'b0;
    checkOutput("pre_rst_valid", 32'(dec_valid_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("async_rst_sb_x12", sbCnt(12), 32'd0);
    tick();
    rst_n = 1'b1;
    dec_ready_i = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
